fetch_unit: RTL and testbench

//  Instruction fetch front-end; consumes the PC's Count, reads instruction memory, queues instructions for decode.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 62 ++++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front-end: opcode, FSM states, default depth.
// Optional jump folding in fetch_unit is enabled by defining FETCH_JUMP_FOLD_EN.
package fetch_pkg;

    localparam logic [5:0] OP_J        = 6'h02;
    localparam int         FETCH_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue, DEPTH entries of W bits, with synchronous flush.
// Head is read straight from storage, so a push becomes visible the following cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign valid   = (count_reg != '0);
    assign full    = (count_reg == DEPTH_C);
    assign push_ok = push && !full;
    assign pop_ok  = pop && valid;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: holds/releases/redirects the PC, reads imem, queues instructions.
// Define FETCH_JUMP_FOLD_EN to resolve J instructions in fetch instead of sending them to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc_count,
    output logic [AW-1:0] jump,
    output logic [AW-1:0] branch,
    output logic          sel_j,
    output logic          sel_b,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [DW-1:0] instr_data,
    output logic [AW-1:0] instr_pc,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target
);

    localparam int QW = AW + DW;

    fetch_state_t  state_reg;
    logic [AW-1:0] req_addr_reg;
    logic          req_reg;
    logic          ack_ok;
    logic          fold_j;
    logic          q_push;
    logic          q_pop;
    logic          q_full;
    logic [QW-1:0] q_head;

    // An ack only counts when it answers a live request and no flush overrides it.
    assign ack_ok = (state_reg == S_REQ) && imem_ack && !br_taken;

`ifdef FETCH_JUMP_FOLD_EN
    logic [AW-1:0] jump_target;
    assign fold_j      = ack_ok && (imem_rdata[31:26] == OP_J);
    assign jump_target = {req_addr_reg[AW-1:26], imem_rdata[25:0]};
`else
    assign fold_j = 1'b0;
`endif

    assign q_push    = ack_ok && !fold_j;
    assign q_pop     = instr_valid && instr_ready;
    assign imem_req  = req_reg;
    assign imem_addr = req_addr_reg;
    assign instr_pc  = q_head[QW-1:DW];
    assign instr_data = q_head[DW-1:0];

    fetch_queue #(
        .DEPTH (DEPTH),
        .W     (QW)
    ) u_queue (
        .clk       (clk),
        .srst      (reset),
        .clear     (br_taken),
        .push      (q_push),
        .push_data ({req_addr_reg, imem_rdata}),
        .pop       (q_pop),
        .head      (q_head),
        .valid     (instr_valid),
        .full      (q_full)
    );

    // PC control: the PC advances only on an accepted ack; otherwise it is held or redirected.
    always_comb begin
        sel_j  = 1'b0;
        sel_b  = 1'b0;
        branch = '0;
        jump   = '0;
        if (reset) begin
            sel_b = 1'b0;
        end else if (br_taken) begin
            sel_b  = 1'b1;
            branch = br_target;
        end else if (ack_ok) begin
`ifdef FETCH_JUMP_FOLD_EN
            if (fold_j) begin
                sel_j = 1'b1;
                jump  = jump_target;
            end
`endif
        end else begin
            sel_b  = 1'b1;
            branch = pc_count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            req_addr_reg <= '0;
            req_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (!br_taken && !q_full) begin
                        req_addr_reg <= pc_count;
                        req_reg      <= 1'b1;
                        state_reg    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        req_reg   <= 1'b0;
                        state_reg <= S_IDLE;
                    end else if (br_taken) begin
                        state_reg <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Read is still outstanding; its data is discarded when it lands.
                    if (imem_ack) begin
                        req_reg   <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    req_reg   <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: models the PC and instruction memory, scoreboards queued instructions.
// Build with FETCH_JUMP_FOLD_EN defined to exercise jump folding.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_count;
    logic [AW-1:0] jump;
    logic [AW-1:0] branch;
    logic          sel_j;
    logic          sel_b;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          br_taken;
    logic [AW-1:0] br_target;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_count    (pc_count),
        .jump        (jump),
        .branch      (branch),
        .sel_j       (sel_j),
        .sel_b       (sel_b),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .br_taken    (br_taken),
        .br_target   (br_target)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Stimulus for the next cycle, applied at the falling edge.
    logic          nxt_reset    = 1'b1;
    logic          nxt_ready    = 1'b0;
    logic          nxt_br_taken = 1'b0;
    logic [AW-1:0] nxt_target   = '0;

    logic [AW-1:0]    pc_model  = '0;
    int               ack_delay = 0;
    bit               busy      = 0;
    int               wait_cnt  = 0;
    logic [AW-1:0]    busy_addr = '0;
    bit               dropped   = 0;
    bit               jmode     = 0;
    int               rst_cycles = 0;
    logic [AW+DW-1:0] sb [$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (jmode && a == 32'h20) return 32'h0800_0123;
        return {6'h3F, a[25:0] ^ 26'h15A5A5};
    endfunction

    task automatic cycle();
        logic [AW-1:0]    exp_branch;
        logic [AW-1:0]    exp_jump;
        logic [AW+DW-1:0] exp_entry;
        logic [DW-1:0]    word;
        bit               exp_sb;
        bit               exp_sj;
        bit               accepted;
        bit               is_j;
        @(negedge clk);
        reset       = nxt_reset;
        instr_ready = nxt_ready;
        br_taken    = nxt_br_taken;
        br_target   = nxt_target;
        pc_count    = pc_model;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        if (reset) begin
            busy = 0;
        end else begin
            if (imem_req && !busy) begin
                busy      = 1;
                wait_cnt  = ack_delay;
                busy_addr = pc_model;
                dropped   = 0;
            end
            if (busy) begin
                check_val("imem_req_hold", 64'(imem_req), 64'(1));
                check_val("imem_addr", 64'(imem_addr), 64'(busy_addr));
                if (wait_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(busy_addr);
                end else begin
                    wait_cnt--;
                end
            end
        end
        #1;
        if (reset) begin
            check_val("rst_sel_b", 64'(sel_b), 64'(0));
            check_val("rst_branch", 64'(branch), 64'(0));
            check_val("rst_sel_j", 64'(sel_j), 64'(0));
            check_val("rst_jump", 64'(jump), 64'(0));
            if (rst_cycles > 0) begin
                check_val("rst_imem_req", 64'(imem_req), 64'(0));
                check_val("rst_imem_addr", 64'(imem_addr), 64'(0));
                check_val("rst_instr_valid", 64'(instr_valid), 64'(0));
            end
            rst_cycles++;
            sb.delete();
            pc_model = '0;
            $display("cycle reset: pc=%h", pc_count);
        end else begin
            rst_cycles = 0;
            word     = imem_rdata;
            accepted = imem_ack && !dropped && !br_taken;
            is_j     = 0;
`ifdef FETCH_JUMP_FOLD_EN
            is_j = accepted && (word[31:26] == OP_J);
`endif
            exp_sj     = 0;
            exp_jump   = '0;
            exp_branch = '0;
            if (br_taken) begin
                exp_sb     = 1;
                exp_branch = br_target;
            end else if (accepted) begin
                exp_sb = 0;
                if (is_j) begin
                    exp_sj   = 1;
                    exp_jump = {busy_addr[AW-1:26], word[25:0]};
                end
            end else begin
                exp_sb     = 1;
                exp_branch = pc_model;
            end
            check_val("sel_b", 64'(sel_b), 64'(exp_sb));
            check_val("sel_j", 64'(sel_j), 64'(exp_sj));
            if (exp_sb) check_val("branch", 64'(branch), 64'(exp_branch));
`ifdef FETCH_JUMP_FOLD_EN
            if (exp_sj) check_val("jump", 64'(jump), 64'(exp_jump));
`else
            check_val("jump_tied0", 64'(jump), 64'(0));
`endif
            check_val("instr_valid", 64'(instr_valid), 64'(sb.size() != 0));
            if (instr_valid && instr_ready && sb.size() != 0) begin
                exp_entry = sb.pop_front();
                check_val("instr_pc", 64'(instr_pc), 64'(exp_entry[AW+DW-1:DW]));
                check_val("instr_data", 64'(instr_data), 64'(exp_entry[DW-1:0]));
            end
            if (br_taken) begin
                sb.delete();
                if (busy && !imem_ack) dropped = 1;
            end
            if (accepted && !is_j) sb.push_back({busy_addr, word});
            if (imem_ack) busy = 0;
            $display("cycle pc=%h req=%0d addr=%h ack=%0d br=%0d sel_b=%0d sel_j=%0d valid=%0d",
                     pc_count, imem_req, imem_addr, imem_ack, br_taken, sel_b, sel_j, instr_valid);
            if (exp_sj)      pc_model = exp_jump;
            else if (exp_sb) pc_model = exp_branch;
            else             pc_model = pc_model + 1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic redirect(input logic [AW-1:0] target);
        nxt_br_taken = 1'b1;
        nxt_target   = target;
        cycle();
        nxt_br_taken = 1'b0;
    endtask

    task automatic wait_busy_cnt(input int target);
        int k;
        k = 0;
        while (!(busy && wait_cnt == target) && k < 200) begin
            cycle();
            k++;
        end
        check_val("wait_bound", 64'(k >= 200), 64'(0));
    endtask

    initial begin
        reset       = 1'b1;
        instr_ready = 1'b0;
        br_taken    = 1'b0;
        br_target   = '0;
        pc_count    = '0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;

        run(3);
        nxt_reset = 1'b0;

        // Fill the queue with decode stalled: four pushes then the PC sits at 4.
        run(12);
        check_val("full_no_req", 64'(imem_req), 64'(0));
        check_val("full_hold_pc", 64'(branch), 64'(4));
        check_val("full_valid", 64'(instr_valid), 64'(1));
        nxt_ready = 1'b1;
        run(10);

        // Slow memory at 0x10.
        ack_delay = 3;
        redirect(32'h10);
        run(20);

        // Flush while a read is pending: queue empties, read is drained and dropped.
        wait_busy_cnt(2);
        redirect(32'h40);
        cycle();
        check_val("drain_req", 64'(imem_req), 64'(1));
        check_val("flush_empty", 64'(instr_valid), 64'(0));
        run(15);

        // Flush in the same cycle as the ack.
        ack_delay = 2;
        wait_busy_cnt(0);
        redirect(32'h80);
        check_val("collide_sel_j", 64'(sel_j), 64'(0));
        cycle();
        check_val("collide_idle", 64'(imem_req), 64'(0));
        run(10);

        // J instruction at 0x20.
        ack_delay = 0;
        jmode     = 1;
        redirect(32'h20);
        run(12);
        jmode = 0;
        run(6);

        // Reset in the middle of a pending read.
        ack_delay = 3;
        wait_busy_cnt(1);
        nxt_reset = 1'b1;
        run(2);
        nxt_reset = 1'b0;
        run(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
